apb_fsm_controller: RTL and testbench

AHB-to-APB bridge sequencer. Takes the validated, pipelined AHB transfer from the AHB slave interface and drives the APB master side: two-phase APB SETUP/ENABLE sequencing, peripheral select decode, and HREADYOUT back-pressure to the AHB master. It sits between the AHB slave interface and up to three APB peripherals, and is the only block that drives APB signals.

---
 rtl/apb_fsm_controller.sv | 172 +++++++++++++++++
 tb/tb_apb_fsm_controller.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_fsm_controller.sv
// AHB-to-APB bridge sequencer: drives APB SETUP/ENABLE phases, decodes
// the peripheral select and back-pressures the AHB master via hreadyout.
module apb_fsm_controller #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter logic [31:0] SLOT_SIZE = 32'h0400_0000
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        valid,
    input  logic        hwrite,
    input  logic        hwritereg,
    input  logic [31:0] haddr,
    input  logic [31:0] haddr1,
    input  logic [31:0] haddr2,
    input  logic [31:0] hwdata,
    input  logic [31:0] hwdata1,
    input  logic [31:0] prdata,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    output logic        pwrite,
    output logic [2:0]  pselx,
    output logic        penable,
    output logic        hreadyout,
    output logic [31:0] hrdata
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_READ     = 3'd1,
        ST_RENABLE  = 3'd2,
        ST_WWAIT    = 3'd3,
        ST_WRITE    = 3'd4,
        ST_WRITEP   = 3'd5,
        ST_WENABLE  = 3'd6,
        ST_WENABLEP = 3'd7
    } state_t;

    // Region limits are held two bits wider so 3*SLOT_SIZE cannot wrap.
    localparam logic [33:0] LIMIT0 = {2'b00, SLOT_SIZE};
    localparam logic [33:0] LIMIT1 = LIMIT0 + LIMIT0;
    localparam logic [33:0] LIMIT2 = LIMIT1 + LIMIT0;

    state_t      r_state;
    state_t      w_nextState;
    logic [31:0] r_paddr;
    logic [31:0] r_pwdata;
    logic        r_pwrite;
    logic [2:0]  r_pselx;
    logic        r_penable;
    logic        r_hreadyout;
    logic [31:0] w_nextPaddr;
    logic [31:0] w_nextPwdata;
    logic        w_nextPwrite;
    logic [2:0]  w_nextPselx;
    logic        w_nextPenable;
    logic        w_nextHreadyout;

    // Addresses below the base wrap to a huge offset and select nothing.
    function automatic logic [2:0] decodeSelect(input logic [31:0] addr);
        logic [33:0] offset;
        offset = {2'b00, addr - BASE_ADDR};
        if (offset < LIMIT0)      return 3'b001;
        else if (offset < LIMIT1) return 3'b010;
        else if (offset < LIMIT2) return 3'b100;
        else                      return 3'b000;
    endfunction

    // Next-state decode; the pipelined write states let back-to-back writes
    // use the delayed address/data copies while the AHB side keeps moving.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE, ST_RENABLE, ST_WENABLE: begin
                if (valid && !hwrite)     w_nextState = ST_READ;
                else if (valid && hwrite) w_nextState = ST_WWAIT;
                else                      w_nextState = ST_IDLE;
            end
            ST_READ:   w_nextState = ST_RENABLE;
            ST_WWAIT:  w_nextState = valid ? ST_WRITEP : ST_WRITE;
            ST_WRITE:  w_nextState = valid ? ST_WENABLEP : ST_WENABLE;
            ST_WRITEP: w_nextState = ST_WENABLEP;
            ST_WENABLEP: begin
                if (!hwritereg)  w_nextState = ST_READ;
                else if (valid)  w_nextState = ST_WRITEP;
                else             w_nextState = ST_WRITE;
            end
            default:   w_nextState = ST_IDLE;
        endcase
    end

    // Output values for the state being entered; the source of address and
    // data depends on how far the AHB pipeline has advanced past the transfer.
    always_comb begin
        w_nextPaddr     = r_paddr;
        w_nextPwdata    = r_pwdata;
        w_nextPwrite    = r_pwrite;
        w_nextPselx     = r_pselx;
        w_nextPenable   = r_penable;
        w_nextHreadyout = r_hreadyout;
        case (w_nextState)
            ST_READ: begin
                if (r_state == ST_WENABLEP) begin
                    w_nextPaddr = haddr1;
                    w_nextPselx = decodeSelect(haddr1);
                end else begin
                    w_nextPaddr = haddr;
                    w_nextPselx = decodeSelect(haddr);
                end
                w_nextPwrite    = 1'b0;
                w_nextPenable   = 1'b0;
                w_nextHreadyout = 1'b0;
            end
            ST_WRITE, ST_WRITEP: begin
                if (r_state == ST_WENABLEP) begin
                    w_nextPaddr  = haddr2;
                    w_nextPwdata = hwdata1;
                    w_nextPselx  = decodeSelect(haddr2);
                end else begin
                    w_nextPaddr  = haddr1;
                    w_nextPwdata = hwdata;
                    w_nextPselx  = decodeSelect(haddr1);
                end
                w_nextPwrite    = 1'b1;
                w_nextPenable   = 1'b0;
                w_nextHreadyout = 1'b0;
            end
            ST_RENABLE, ST_WENABLE, ST_WENABLEP: begin
                w_nextPenable   = 1'b1;
                w_nextHreadyout = 1'b1;
            end
            default: begin
                w_nextPselx     = 3'b000;
                w_nextPenable   = 1'b0;
                w_nextHreadyout = 1'b1;
            end
        endcase
    end

    // State register; reset abandons any APB transfer in flight.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) r_state <= ST_IDLE;
        else          r_state <= w_nextState;
    end

    // Registered APB and AHB-ready outputs.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_paddr     <= 32'h0;
            r_pwdata    <= 32'h0;
            r_pwrite    <= 1'b0;
            r_pselx     <= 3'b000;
            r_penable   <= 1'b0;
            r_hreadyout <= 1'b1;
        end else begin
            r_paddr     <= w_nextPaddr;
            r_pwdata    <= w_nextPwdata;
            r_pwrite    <= w_nextPwrite;
            r_pselx     <= w_nextPselx;
            r_penable   <= w_nextPenable;
            r_hreadyout <= w_nextHreadyout;
        end
    end

    assign paddr     = r_paddr;
    assign pwdata    = r_pwdata;
    assign pwrite    = r_pwrite;
    assign pselx     = r_pselx;
    assign penable   = r_penable;
    assign hreadyout = r_hreadyout;
    assign hrdata    = prdata;

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Directed bench for apb_fsm_controller; models the AHB slave-side delay
// registers (haddr1/haddr2/hwdata1/hwritereg) and checks every APB output.
module tb_apb_fsm_controller;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        valid;
    logic        hwrite;
    logic        hwritereg = 1'b0;
    logic [31:0] haddr;
    logic [31:0] haddr1 = 32'h0;
    logic [31:0] haddr2 = 32'h0;
    logic [31:0] hwdata;
    logic [31:0] hwdata1 = 32'h0;
    logic [31:0] prdata;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pwrite;
    logic [2:0]  pselx;
    logic        penable;
    logic        hreadyout;
    logic [31:0] hrdata;

    int checkCount = 0;
    int errorCount = 0;

    apb_fsm_controller dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .valid     (valid),
        .hwrite    (hwrite),
        .hwritereg (hwritereg),
        .haddr     (haddr),
        .haddr1    (haddr1),
        .haddr2    (haddr2),
        .hwdata    (hwdata),
        .hwdata1   (hwdata1),
        .prdata    (prdata),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pwrite    (pwrite),
        .pselx     (pselx),
        .penable   (penable),
        .hreadyout (hreadyout),
        .hrdata    (hrdata)
    );

    // 10-unit clock period.
    always #5 hclk = ~hclk;

    // AHB slave-side delay registers feeding the sequencer.
    always @(posedge hclk) begin
        haddr1    <= haddr;
        haddr2    <= haddr1;
        hwdata1   <= hwdata;
        hwritereg <= hwrite;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) else begin
            errorCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one AHB cycle, then sample just after the rising edge.
    task automatic applyStimulus(input logic v, input logic w,
                                 input logic [31:0] addr, input logic [31:0] data);
        valid  = v;
        hwrite = w;
        haddr  = addr;
        hwdata = data;
        @(posedge hclk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] expPaddr,
                               input logic [31:0] expPwdata, input logic expPwrite,
                               input logic [2:0] expPsel, input logic expPen,
                               input logic expRdy);
        chk({tag, " paddr"},     paddr,     expPaddr);
        chk({tag, " pwdata"},    pwdata,    expPwdata);
        chk({tag, " pwrite"},    {31'b0, pwrite},    {31'b0, expPwrite});
        chk({tag, " pselx"},     {29'b0, pselx},     {29'b0, expPsel});
        chk({tag, " penable"},   {31'b0, penable},   {31'b0, expPen});
        chk({tag, " hreadyout"}, {31'b0, hreadyout}, {31'b0, expRdy});
    endtask

    // Safety net so the run always ends.
    initial begin
        #50000;
        $display("[TB] FAIL timeout: observed running expected finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        hresetn = 1'b0;
        valid   = 1'b0;
        hwrite  = 1'b0;
        haddr   = 32'h0;
        hwdata  = 32'h0;
        prdata  = 32'hDEAD_BEEF;
        #12;
        checkOutput("reset", 32'h0, 32'h0, 1'b0, 3'b000, 1'b0, 1'b1);
        hresetn = 1'b1;

        // Single read of region 1.
        applyStimulus(1'b1, 1'b0, 32'h8400_0010, 32'h0);
        checkOutput("rd setup", 32'h8400_0010, 32'h0, 1'b0, 3'b010, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h8400_0010, 32'h0);
        checkOutput("rd enable", 32'h8400_0010, 32'h0, 1'b0, 3'b010, 1'b1, 1'b1);
        chk("rd hrdata", hrdata, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 1'b0, 32'h8400_0010, 32'h0);
        checkOutput("rd idle", 32'h8400_0010, 32'h0, 1'b0, 3'b000, 1'b0, 1'b1);

        // Single write of region 0.
        applyStimulus(1'b1, 1'b1, 32'h8000_0004, 32'h0);
        checkOutput("wr wwait", 32'h8400_0010, 32'h0, 1'b0, 3'b000, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h8000_0004, 32'h1234_5678);
        checkOutput("wr setup", 32'h8000_0004, 32'h1234_5678, 1'b1, 3'b001, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h8000_0004, 32'h1234_5678);
        checkOutput("wr enable", 32'h8000_0004, 32'h1234_5678, 1'b1, 3'b001, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h8000_0004, 32'h0);
        checkOutput("wr idle", 32'h8000_0004, 32'h1234_5678, 1'b1, 3'b000, 1'b0, 1'b1);

        // Three back-to-back writes; the master holds an address while hreadyout is low.
        applyStimulus(1'b1, 1'b1, 32'h8000_0000, 32'h0);
        checkOutput("b2b wwait", 32'h8000_0004, 32'h1234_5678, 1'b1, 3'b000, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h8400_0000, 32'h1);
        checkOutput("b2b setup0", 32'h8000_0000, 32'h1, 1'b1, 3'b001, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h8800_0000, 32'h2);
        checkOutput("b2b enable0", 32'h8000_0000, 32'h1, 1'b1, 3'b001, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h8800_0000, 32'h2);
        checkOutput("b2b setup1", 32'h8400_0000, 32'h2, 1'b1, 3'b010, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h8800_0000, 32'h3);
        checkOutput("b2b enable1", 32'h8400_0000, 32'h2, 1'b1, 3'b010, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h8800_0000, 32'h3);
        checkOutput("b2b setup2", 32'h8800_0000, 32'h3, 1'b1, 3'b100, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h8800_0000, 32'h3);
        checkOutput("b2b enable2", 32'h8800_0000, 32'h3, 1'b1, 3'b100, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h8800_0000, 32'h0);
        checkOutput("b2b idle", 32'h8800_0000, 32'h3, 1'b1, 3'b000, 1'b0, 1'b1);

        // Write immediately followed by a read of region 2.
        applyStimulus(1'b1, 1'b1, 32'h8000_0008, 32'h0);
        checkOutput("wr2rd wwait", 32'h8800_0000, 32'h3, 1'b1, 3'b000, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h8800_0020, 32'hAA);
        checkOutput("wr2rd wsetup", 32'h8000_0008, 32'hAA, 1'b1, 3'b001, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h8800_0020, 32'hAA);
        checkOutput("wr2rd wenable", 32'h8000_0008, 32'hAA, 1'b1, 3'b001, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h8800_0020, 32'h0);
        checkOutput("wr2rd rsetup", 32'h8800_0020, 32'hAA, 1'b0, 3'b100, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h8800_0020, 32'h0);
        checkOutput("wr2rd renable", 32'h8800_0020, 32'hAA, 1'b0, 3'b100, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h8800_0020, 32'h0);
        checkOutput("wr2rd idle", 32'h8800_0020, 32'hAA, 1'b0, 3'b000, 1'b0, 1'b1);

        // Region boundary reads.
        applyStimulus(1'b1, 1'b0, 32'h83FF_FFFC, 32'h0);
        checkOutput("bnd0 setup", 32'h83FF_FFFC, 32'hAA, 1'b0, 3'b001, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h83FF_FFFC, 32'h0);
        checkOutput("bnd0 enable", 32'h83FF_FFFC, 32'hAA, 1'b0, 3'b001, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h83FF_FFFC, 32'h0);
        checkOutput("bnd0 idle", 32'h83FF_FFFC, 32'hAA, 1'b0, 3'b000, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h8400_0000, 32'h0);
        checkOutput("bnd1 setup", 32'h8400_0000, 32'hAA, 1'b0, 3'b010, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h8400_0000, 32'h0);
        checkOutput("bnd1 enable", 32'h8400_0000, 32'hAA, 1'b0, 3'b010, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h8BFF_FFFC, 32'h0);
        checkOutput("bnd2 setup", 32'h8BFF_FFFC, 32'hAA, 1'b0, 3'b100, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h8BFF_FFFC, 32'h0);
        checkOutput("bnd2 enable", 32'h8BFF_FFFC, 32'hAA, 1'b0, 3'b100, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h8C00_0000, 32'h0);
        checkOutput("outside idle", 32'h8BFF_FFFC, 32'hAA, 1'b0, 3'b000, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h8C00_0000, 32'h0);
        checkOutput("outside hold", 32'h8BFF_FFFC, 32'hAA, 1'b0, 3'b000, 1'b0, 1'b1);

        // Asynchronous reset during the ENABLE phase of a write.
        applyStimulus(1'b1, 1'b1, 32'h8000_0010, 32'h0);
        checkOutput("rst wwait", 32'h8BFF_FFFC, 32'hAA, 1'b0, 3'b000, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h8000_0010, 32'h55);
        checkOutput("rst wsetup", 32'h8000_0010, 32'h55, 1'b1, 3'b001, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h8000_0010, 32'h55);
        checkOutput("rst wenable", 32'h8000_0010, 32'h55, 1'b1, 3'b001, 1'b1, 1'b1);
        #2;
        hresetn = 1'b0;
        #1;
        checkOutput("rst async", 32'h0, 32'h0, 1'b0, 3'b000, 1'b0, 1'b1);
        valid  = 1'b0;
        hwrite = 1'b0;
        #2;
        hresetn = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("rst release", 32'h0, 32'h0, 1'b0, 3'b000, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h8400_0000, 32'h0);
        checkOutput("rst then rd", 32'h8400_0000, 32'h0, 1'b0, 3'b010, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h8400_0000, 32'h0);
        checkOutput("rst rd enable", 32'h8400_0000, 32'h0, 1'b0, 3'b010, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
